// File: rtl/bus_byte_serializer.sv
// Debug-bus byte consumer: 4-entry FIFO feeding a framed MSB-first serial line
// (start, 8 data, optional even parity, stop).
module bus_byte_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BAUD_W = 8;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [BAUD_W-1:0]   baud_cnt, baud_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_nx;
  logic [7:0]          shift, shift_nx;
  logic                par, par_nx;
  logic                tx_nx, busy_nx;
  logic                pop, push, last_tick, has_data;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count_nx;
  logic [7:0]          mem [FIFO_DEPTH];

  assign push      = in_valid && in_ready;
  assign has_data  = (count != '0);
  assign last_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign count_nx  = count + CNT_W'(push) - CNT_W'(pop);

  // Next-state, baud/bit counters, pop decision and next registered line values
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    par_nx   = par;
    pop      = 1'b0;
    tx_nx    = 1'b1;
    busy_nx  = 1'b0;

    if (state != IDLE) begin
      baud_nx = last_tick ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        if (has_data) begin
          pop      = 1'b1;
          state_nx = START;
          baud_nx  = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_nx = DATA;
          bit_nx   = '0;
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_cnt == BIT_W'(7)) begin
            state_nx = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_nx   = bit_cnt + BIT_W'(1);
            shift_nx = {shift[6:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (last_tick) state_nx = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit when more bytes are waiting
        if (last_tick) begin
          if (has_data) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (pop) begin
      shift_nx = mem[rd_ptr];
      par_nx   = ^mem[rd_ptr];
    end

    busy_nx = (state_nx != IDLE);
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[7];
      PARITY:  tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  // FSM and serial datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      par      <= par_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
    end
  end

  // FIFO pointers and occupancy; count kept separately so full/empty are distinct
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      wr_ptr   <= wr_ptr + PTR_W'(push);
      count    <= count_nx;
      in_ready <= (count_nx != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_bus_byte_serializer.sv
// Bench for bus_byte_serializer: two instances (no parity / even parity) share
// one stimulus stream and are checked cycle by cycle against a frame-level model.
module tb_bus_byte_serializer;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic [2:0] count_a, count_b;

  bus_byte_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .count(count_a));

  bus_byte_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .count(count_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model per instance: queue of bytes plus the frame being sent
  logic [7:0]  mq  [2][4];
  int          mn  [2];
  bit          act [2];
  int          pos [2];
  logic [10:0] fb  [2];

  function automatic int nbits(input int k);
    return (k == 1) ? 11 : 10;
  endfunction

  function automatic logic exp_tx(input int k);
    if (!act[k]) return 1'b1;
    return fb[k][nbits(k) - 1 - pos[k] / CPB];
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic model_step(input int k);
    bit acc, start;
    logic [7:0] b;
    if (!reset) begin
      mn[k] = 0; act[k] = 1'b0; pos[k] = 0;
    end else begin
      acc = in_valid && (mn[k] < 4);
      start = 1'b0;
      if (act[k]) begin
        if (pos[k] == nbits(k) * CPB - 1) begin
          act[k] = 1'b0;
          start  = (mn[k] != 0);
        end else begin
          pos[k]++;
        end
      end else begin
        start = (mn[k] != 0);
      end
      if (start) begin
        b = mq[k][0];
        for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
        mn[k]--;
        fb[k]  = (k == 1) ? {1'b0, b, ^b, 1'b1} : 11'({1'b0, b, 1'b1});
        pos[k] = 0;
        act[k] = 1'b1;
      end
      if (acc) begin
        mq[k][mn[k]] = in_data;
        mn[k]++;
      end
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("tx_a", 32'(tx_a), 32'(exp_tx(0)));
    chk("busy_a", 32'(busy_a), 32'(act[0]));
    chk("count_a", 32'(count_a), 32'(mn[0]));
    chk("ready_a", 32'(ready_a), 32'(mn[0] != 4));
    chk("tx_b", 32'(tx_b), 32'(exp_tx(1)));
    chk("busy_b", 32'(busy_b), 32'(act[1]));
    chk("count_b", 32'(count_b), 32'(mn[1]));
    chk("ready_b", 32'(ready_b), 32'(mn[1] != 4));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((busy_a || busy_b || count_a != 0 || count_b != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_bounded", 32'(n < 400), 32'd1);
  endtask

  typedef struct packed {
    logic [7:0]  data;
    logic [9:0]  frame_a;
    logic [10:0] frame_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int run_a, run_b, nacc, anybusy, j;
    logic acc;
    logic ea, eb;

    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; act[k] = 1'b0; pos[k] = 0; fb[k] = '1;
      for (int i = 0; i < 4; i++) mq[k][i] = '0;
    end

    // Frames in line order: start, data MSB first, [parity], stop
    vecs[0] = '{8'hEC, 10'b0_11101100_1, 11'b0_11101100_1_1};
    vecs[1] = '{8'h07, 10'b0_00000111_1, 11'b0_00000111_1_1};
    vecs[2] = '{8'h80, 10'b0_10000000_1, 11'b0_10000000_1_1};
    vecs[3] = '{8'h00, 10'b0_00000000_1, 11'b0_00000000_0_1};
    vecs[4] = '{8'hFF, 10'b0_11111111_1, 11'b0_11111111_0_1};
    vecs[5] = '{8'hA5, 10'b0_10100101_1, 11'b0_10100101_0_1};

    do_reset();
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);

    // Single-byte frames, sampled mid-bit against hand-written frames
    for (int v = 0; v < 6; v++) begin
      do_reset();
      in_valid = 1'b1;
      in_data  = vecs[v].data;
      tick();
      in_valid = 1'b0;
      tick();
      run_a = 0;
      run_b = 0;
      for (int c = 0; c < 48; c++) begin
        if (busy_a) run_a++;
        if (busy_b) run_b++;
        if (c % CPB == 1) begin
          ea = (c < 40) ? vecs[v].frame_a[9 - c / CPB] : 1'b1;
          eb = (c < 44) ? vecs[v].frame_b[10 - c / CPB] : 1'b1;
          chk("vec_tx_a", 32'(tx_a), 32'(ea));
          chk("vec_tx_b", 32'(tx_b), 32'(eb));
        end
        tick();
      end
      chk("vec_len_a", 32'(run_a), 32'd40);
      chk("vec_len_b", 32'(run_b), 32'd44);
      chk("vec_count_a", 32'(count_a), 32'd0);
    end

    // Back-to-back: 0x80 then 0x00 with no idle gap between frames
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    run_a = 0;
    run_b = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy_a) run_a++;
      if (busy_b) run_b++;
      if (c == 39) chk("b2b_last_stop_a", 32'(tx_a), 32'd1);
      if (c == 40) begin
        chk("b2b_start_a", 32'(tx_a), 32'd0);
        chk("b2b_busy_a", 32'(busy_a), 32'd1);
      end
      if (c == 44) chk("b2b_start_b", 32'(tx_b), 32'd0);
      tick();
    end
    chk("b2b_len_a", 32'(run_a), 32'd80);
    chk("b2b_len_b", 32'(run_b), 32'd88);

    // Hold valid with six bytes: five accepted, sixth blocked then dropped
    do_reset();
    j = 0;
    nacc = 0;
    in_valid = 1'b1;
    in_data  = 8'h10;
    for (int t = 0; t < 30; t++) begin
      acc = ready_a;
      tick();
      if (acc) begin
        nacc++;
        if (j < 5) j++;
        in_data = 8'h10 + 8'(j);
      end
    end
    chk("fill_accepted", 32'(nacc), 32'd5);
    chk("fill_ready_low", 32'(ready_a), 32'd0);
    chk("fill_count", 32'(count_a), 32'd4);
    drain();

    // Reset mid-DATA with bytes still queued
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h31 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    chk("midrst_tx", 32'(tx_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_count", 32'(count_a), 32'd0);
    reset = 1'b1;
    anybusy = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy_a || busy_b) anybusy++;
    end
    chk("midrst_no_frames", 32'(anybusy), 32'd0);

    // Push on the same edge the FSM pops the last entry
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    chk("pushpop_count", 32'(count_a), 32'd1);
    chk("pushpop_busy", 32'(busy_a), 32'd1);
    drain();

    // Randomised traffic with occasional resets
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      reset    = ($urandom_range(0, 399) != 0);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      tick();
    end
    reset = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_byte_serializer.md
Name: bus_byte_serializer

Overview:
- Consumer end of the 8-bit parallel debug bus; bus producers drive bytes such as {flag, 3'b0} packings.
- Accepts bytes over a valid/ready handshake and buffers them in a 4-entry FIFO.
- Shifts each byte out MSB-first as a framed serial stream: start bit, 8 data bits, optional even parity, stop bit.
- Sits between the debug bus and a single-wire probe/LED output.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit, legal range 1..255.
- PARITY_EN, 0, 1 inserts an even-parity bit between data bit 0 and the stop bit.
- FIFO_DEPTH, 4, buffer entries; fixed power of two.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_data  in  8  byte from the bus.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a byte; equals (count != FIFO_DEPTH).
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is being shifted.
- count  out  3  FIFO occupancy, 0..4.

Behaviour:
- Reset (reset==0 at a clk edge), takes effect immediately:
  - tx=1, busy=0, count=0, in_ready=1.
  - FSM goes to IDLE; FIFO pointers, bit counter and baud counter clear.
  - A frame in progress is abandoned; tx returns high in the same edge.
- Accept: a byte is written when in_valid && in_ready at the edge. in_data is stored unchanged, no field extraction.
- FSM states:
  - IDLE: when count!=0, pop the head into an 8-bit shift register and go to START. Pop latency is 1 cycle after the write is visible in count.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[7]; every CLKS_PER_BIT cycles shift left by one. After 8 bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the 8 data bits, so the frame has even parity. Lasts CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to START directly if count!=0 (back-to-back frames, no idle gap), else IDLE.
- busy is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Frame length is (10+PARITY_EN)*CLKS_PER_BIT cycles.
- Baud counter: runs 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary.
- Simultaneous push and pop in one cycle: count unchanged; both operations take effect.
  - Push while full is blocked by in_ready=0.
  - Pop while empty cannot happen.
- Full: in_ready=0; in_data is ignored even if in_valid=1.
- Pointers: 2-bit read/write pointers wrap modulo 4. count is tracked separately so full and empty are unambiguous.
- tx is registered, so there are no combinational glitches.
- in_valid may drop at any time with no penalty.

Test Plan:
- Reset, then push 8'hEC with CLKS_PER_BIT=4, PARITY_EN=0 -> tx=0 for 4 cycles, then 1,1,1,0,1,1,0,0 for 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles; count returns to 0.
- Push 8'h80 then 8'h00 on consecutive cycles -> two frames back-to-back; the second start bit begins the cycle after the first stop bit ends; no idle gap.
- Hold in_valid=1 with 6 distinct bytes while tx is idle at start -> in_ready falls once count=4; exactly 5 bytes accepted (one popped immediately); bytes emitted in push order; the blocked 6th byte is lost only if in_valid is dropped.
- PARITY_EN=1, push 8'h07 -> parity bit=1; frame lasts 44 cycles with CLKS_PER_BIT=4.
- Assert reset low mid-DATA with 2 bytes queued -> next edge: tx=1, busy=0, count=0; no further frames.
- Push on the exact cycle the FSM pops the last entry -> count stays 1; the new byte follows as the next frame.
